// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port integer register file.
//   Registered reads (1-cycle latency), optional write-to-read bypass,
//   per-port read enables that hold the output, optional hardwired x0.
//   A clear sequencer zeroes every entry after reset or on clr, so the
//   storage array itself carries no reset and can map onto RAM.
// Ports:
//   clk, rst        core clock (rising edge), async active-high reset
//   clr             synchronous clear request (pulse or level)
//   ready           high while in RUN (reads and writes serviced)
//   wr, rd, rd_d    write enable / address / data
//   rs_en           per-port read enable [NRD]
//   rs_addr         read addresses, port i = [i*AW +: AW]
//   rs_data         read data,      port i = [i*XLEN +: XLEN]

// One registered read port: flush to zero, hold when disabled,
// otherwise zero-reg / bypass / array value.
module regfile_mp_rport #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            en,
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] mem_q,
  input  logic            wr_eff,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] rd_d,
  output logic [XLEN-1:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        q <= '0;
    else if (flush) q <= '0;
    else if (en) begin
      if (ZERO_REG && addr == '0)               q <= '0;
      else if (BYPASS && wr_eff && rd == addr)  q <= rd_d;
      else                                      q <= mem_q;
    end
  end
endmodule

module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  output logic                          ready,
  input  logic                          wr,
  input  logic [$clog2(NREG)-1:0]       rd,
  input  logic [XLEN-1:0]               rd_d,
  input  logic [NRD-1:0]                rs_en,
  input  logic [NRD*$clog2(NREG)-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0]           rs_data
);
  localparam int AW = $clog2(NREG);

  if (NREG < 2 || (1 << AW) != NREG) begin : g_bad_nreg
    $error("regfile_mp: NREG must be a power of two >= 2");
  end
  if (NRD < 1 || NRD > 4) begin : g_bad_nrd
    $error("regfile_mp: NRD must be 1..4");
  end

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t          state, state_n;
  logic [AW-1:0]   idx, idx_n;
  logic            wr_eff;
  logic            flush;
  logic [XLEN-1:0] mem [NREG];

  // Sequencer: CLEAR walks idx over every entry, then drops into RUN.
  // clr from either state restarts the walk at entry 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_CLEAR;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    if (clr) begin
      state_n = S_CLEAR;
      idx_n   = '0;
    end else if (state == S_CLEAR) begin
      if (idx == AW'(NREG - 1)) begin
        state_n = S_RUN;
        idx_n   = '0;
      end else begin
        idx_n = idx + 1'b1;
      end
    end
  end

  assign ready  = (state == S_RUN);
  // clr beats a simultaneous write; x0 writes vanish when hardwired.
  assign wr_eff = wr && ready && !clr && !(ZERO_REG && rd == '0);
  assign flush  = (state == S_CLEAR) || clr;

  // Storage has no reset: the sequencer's zero writes stand in for it.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) mem[idx] <= '0;
    else if (wr_eff)      mem[rd]  <= rd_d;
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rport
    regfile_mp_rport #(
      .XLEN(XLEN), .AW(AW), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_rport (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .en    (rs_en[i]),
      .addr  (rs_addr[i*AW +: AW]),
      .mem_q (mem[rs_addr[i*AW +: AW]]),
      .wr_eff(wr_eff),
      .rd    (rd),
      .rd_d  (rd_d),
      .q     (rs_data[i*XLEN +: XLEN])
    );
  end

`ifdef __sim__
  // Debug view of the array: g_dbg[n].r mirrors entry n (g_dbg[0].r is x0).
  for (genvar g = 0; g < NREG; g++) begin : g_dbg
    logic [XLEN-1:0] r;
    assign r = mem[g];
  end
`endif
endmodule
